// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the 5-stage CPU pipeline control
package cpu_pkg;
    localparam int RN_W_DEF = 5;
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EXE = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    typedef enum logic {RUN = 1'b0, MUL_WAIT = 1'b1} state_t;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID-stage instruction info in, pipeline hold/flush/forward controls out
interface hazard_ctrl_if
    import cpu_pkg::*;
#(
    parameter int RN_W = RN_W_DEF
);
    logic            id_valid;
    logic [RN_W-1:0] id_rs;
    logic [RN_W-1:0] id_rt;
    logic            id_use_rs;
    logic            id_use_rt;
    logic            id_wreg;
    logic            id_m2reg;
    logic [RN_W-1:0] id_rn;
    logic            id_mul;
    logic            id_branch_taken;
    logic            stall;
    logic            bubble;
    logic            flush;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic            mul_busy;
    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_rn, id_mul, id_branch_taken,
        input  stall, bubble, flush, fwd_a, fwd_b, mul_busy
    );
    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_rn, id_mul, id_branch_taken,
        output stall, bubble, flush, fwd_a, fwd_b, mul_busy
    );
endinterface

// File: rtl/hazard_match.sv
// hazard_match: compares one ID source register against the EXE and MEM destination shadows
module hazard_match
    import cpu_pkg::*;
#(
    parameter int RN_W = RN_W_DEF
) (
    input  logic [RN_W-1:0] src,
    input  logic            use_src,
    input  logic [RN_W-1:0] exe_rn,
    input  logic            exe_wreg,
    input  logic [RN_W-1:0] mem_rn,
    input  logic            mem_wreg,
    output logic            exe_hit,
    output logic            mem_hit
);
    logic live;
    assign live    = use_src && src != '0;
    assign exe_hit = live && exe_wreg && exe_rn == src;
    assign mem_hit = live && mem_wreg && mem_rn == src;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble/flush, operand forwarding and multi-cycle multiply sequencing; HAZARD_FWD_EN enables forwarding
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int RN_W       = RN_W_DEF,
    parameter int MUL_CYCLES = 4
) (
    input logic          clk,
    input logic          clr,
    hazard_ctrl_if.slave bus
);
    localparam logic       SHORT_MUL = MUL_CYCLES == 2;
    localparam logic [3:0] MUL_LOAD  = 4'(MUL_CYCLES - 2);
    logic [RN_W-1:0] exe_rn, mem_rn;
    logic            exe_wreg, mem_wreg;
    logic            a_exe, a_mem, b_exe, b_mem;
    logic            hz, start, busy, hold, issue, done;
    logic [3:0]      mul_cnt;
    state_t          state, state_n;

    hazard_match #(.RN_W(RN_W)) u_match_rs (
        .src(bus.id_rs), .use_src(bus.id_use_rs),
        .exe_rn(exe_rn), .exe_wreg(exe_wreg), .mem_rn(mem_rn), .mem_wreg(mem_wreg),
        .exe_hit(a_exe), .mem_hit(a_mem)
    );
    hazard_match #(.RN_W(RN_W)) u_match_rt (
        .src(bus.id_rt), .use_src(bus.id_use_rt),
        .exe_rn(exe_rn), .exe_wreg(exe_wreg), .mem_rn(mem_rn), .mem_wreg(mem_wreg),
        .exe_hit(b_exe), .mem_hit(b_mem)
    );

`ifdef HAZARD_FWD_EN
    logic exe_m2reg;
    assign hz        = (a_exe || b_exe) && exe_m2reg;
    assign bus.fwd_a = (a_exe && !exe_m2reg) ? FWD_EXE : a_mem ? FWD_MEM : FWD_REG;
    assign bus.fwd_b = (b_exe && !exe_m2reg) ? FWD_EXE : b_mem ? FWD_MEM : FWD_REG;
    // load flag follows its instruction into EXE; a load there cannot be forwarded yet
    always_ff @(posedge clk) begin
        if (clr) exe_m2reg <= 1'b0;
        else     exe_m2reg <= issue && bus.id_m2reg;
    end
`else
    assign hz        = a_exe || b_exe || a_mem || b_mem;
    assign bus.fwd_a = FWD_REG;
    assign bus.fwd_b = FWD_REG;
`endif

    // multiply sequencing and the shared hold condition; done blocks re-triggering on the finished mul
    always_comb begin
        busy    = state == MUL_WAIT;
        start   = state == RUN && bus.id_valid && bus.id_mul && !hz && !done;
        state_n = start ? (SHORT_MUL ? RUN : MUL_WAIT) : (busy && mul_cnt == 4'd1) ? RUN : state;
        hold    = hz || start || busy;
        issue   = bus.id_valid && !hold;
    end

    assign bus.stall    = hold;
    assign bus.bubble   = hold;
    assign bus.mul_busy = busy;
    assign bus.flush    = bus.id_valid && bus.id_branch_taken && !hold;

    // FSM state, remaining wait cycles (including the current one) and completion marker
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= RUN;
            mul_cnt <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            mul_cnt <= start ? MUL_LOAD : busy ? mul_cnt - 4'd1 : mul_cnt;
            done    <= state_n == RUN && (busy || start);
        end
    end

    // destination shadows: MEM takes EXE, EXE takes the issuing instruction or a NOP
    always_ff @(posedge clk) begin
        if (clr) begin
            exe_rn   <= '0;
            exe_wreg <= 1'b0;
            mem_rn   <= '0;
            mem_wreg <= 1'b0;
        end else begin
            mem_rn   <= exe_rn;
            mem_wreg <= exe_wreg;
            exe_rn   <= issue ? bus.id_rn : '0;
            exe_wreg <= issue && bus.id_wreg;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl; expectations follow HAZARD_FWD_EN
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int   vecs = 0;
    int   errs = 0;
    logic [7:0] obs;

    hazard_ctrl_if #(.RN_W(5)) bus ();
    hazard_ctrl #(.RN_W(5), .MUL_CYCLES(4)) dut (.clk(clk), .clr(clr), .bus(bus));

    assign obs = {bus.stall, bus.bubble, bus.flush, bus.mul_busy, bus.fwd_a, bus.fwd_b};

    always #5 clk = ~clk;

    task automatic drive(input int v, input int rs, input int urs, input int rt, input int urt,
                         input int w, input int m, input int rn, input int mul, input int br);
        bus.id_valid        = v != 0;
        bus.id_rs           = 5'(rs);
        bus.id_use_rs       = urs != 0;
        bus.id_rt           = 5'(rt);
        bus.id_use_rt       = urt != 0;
        bus.id_wreg         = w != 0;
        bus.id_m2reg        = m != 0;
        bus.id_rn           = 5'(rn);
        bus.id_mul          = mul != 0;
        bus.id_branch_taken = br != 0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) adv();
    endtask

    task automatic test_reset();
        clr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive($urandom_range(1, 0), $urandom_range(31, 0), $urandom_range(1, 0), $urandom_range(31, 0),
                  $urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(31, 0),
                  $urandom_range(1, 0), $urandom_range(1, 0));
            adv();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); vecs++;
        if (obs !== 8'h00) begin errs++; $display("FAIL reset_held: got %h want %h", obs, 8'h00); end
        adv();
        clr = 1'b0;
        @(negedge clk); vecs++;
        if (obs !== 8'h00) begin errs++; $display("FAIL reset_release: got %h want %h", obs, 8'h00); end
        adv();
    endtask

    task automatic test_fwd_chain();
        drive(1, 0, 0, 0, 0, 1, 0, 3, 0, 0);
        @(negedge clk); vecs++;
        if (obs !== 8'h00) begin errs++; $display("FAIL add_r3: got %h want %h", obs, 8'h00); end
        adv();
        drive(1, 3, 1, 0, 0, 1, 0, 4, 0, 0);
`ifdef HAZARD_FWD_EN
        @(negedge clk); vecs++;
        if (obs !== 8'h04) begin errs++; $display("FAIL sub_fwd_a_exe: got %h want %h", obs, 8'h04); end
        adv();
`else
        @(negedge clk); vecs++;
        if (obs !== 8'hC0) begin errs++; $display("FAIL sub_stall_exe: got %h want %h", obs, 8'hC0); end
        adv();
        @(negedge clk); vecs++;
        if (obs !== 8'hC0) begin errs++; $display("FAIL sub_stall_mem: got %h want %h", obs, 8'hC0); end
        adv();
        @(negedge clk); vecs++;
        if (obs !== 8'h00) begin errs++; $display("FAIL sub_issue: got %h want %h", obs, 8'h00); end
        adv();
`endif
        drive(1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
        @(negedge clk); vecs++;
        if (obs !== 8'h02) begin errs++; $display("FAIL rt_fwd_b_mem: got %h want %h", obs, 8'h02); end
`else
        @(negedge clk); vecs++;
        if (obs !== 8'h00) begin errs++; $display("FAIL rt_after_drain: got %h want %h", obs, 8'h00); end
`endif
        adv();
        idle(3);
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        @(negedge clk); vecs++;
        if (obs !== 8'h00) begin errs++; $display("FAIL r0_write: got %h want %h", obs, 8'h00); end
        adv();
        drive(1, 0, 1, 0, 1, 1, 0, 5, 0, 0);
        @(negedge clk); vecs++;
        if (obs !== 8'h00) begin errs++; $display("FAIL r0_read: got %h want %h", obs, 8'h00); end
        adv();
        idle(3);
    endtask

    task automatic test_priority();
        drive(1, 0, 0, 0, 0, 1, 0, 3, 0, 0);
        adv();
        drive(1, 0, 0, 0, 0, 1, 0, 3, 0, 0);
        @(negedge clk); vecs++;
        if (obs !== 8'h00) begin errs++; $display("FAIL prio_second_add: got %h want %h", obs, 8'h00); end
        adv();
        drive(1, 3, 1, 3, 1, 0, 0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
        @(negedge clk); vecs++;
        if (obs !== 8'h05) begin errs++; $display("FAIL prio_exe_over_mem: got %h want %h", obs, 8'h05); end
`else
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); vecs++;
            if (obs !== 8'hC0) begin errs++; $display("FAIL prio_stall%0d: got %h want %h", i, obs, 8'hC0); end
            adv();
        end
        @(negedge clk); vecs++;
        if (obs !== 8'h00) begin errs++; $display("FAIL prio_issue: got %h want %h", obs, 8'h00); end
`endif
        adv();
        idle(3);
    endtask

    task automatic test_load_use();
        drive(1, 0, 0, 0, 0, 1, 1, 5, 0, 0);
        @(negedge clk); vecs++;
        if (obs !== 8'h00) begin errs++; $display("FAIL load_issue: got %h want %h", obs, 8'h00); end
        adv();
        drive(1, 5, 1, 0, 0, 1, 0, 6, 0, 0);
        @(negedge clk); vecs++;
        if (obs !== 8'hC0) begin errs++; $display("FAIL load_use_stall: got %h want %h", obs, 8'hC0); end
        adv();
`ifdef HAZARD_FWD_EN
        @(negedge clk); vecs++;
        if (obs !== 8'h08) begin errs++; $display("FAIL load_use_fwd_mem: got %h want %h", obs, 8'h08); end
        adv();
`else
        @(negedge clk); vecs++;
        if (obs !== 8'hC0) begin errs++; $display("FAIL load_use_stall_mem: got %h want %h", obs, 8'hC0); end
        adv();
        @(negedge clk); vecs++;
        if (obs !== 8'h00) begin errs++; $display("FAIL load_use_issue: got %h want %h", obs, 8'h00); end
        adv();
`endif
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); vecs++;
        if (obs !== 8'h00) begin errs++; $display("FAIL load_use_no_more: got %h want %h", obs, 8'h00); end
        adv();
        idle(3);
    endtask

    task automatic test_mul();
        logic [7:0] exp [4] = '{8'hC0, 8'hD0, 8'hD0, 8'h00};
        drive(1, 0, 0, 0, 0, 1, 0, 7, 1, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); vecs++;
            if (obs !== exp[i]) begin errs++; $display("FAIL mul_c%0d: got %h want %h", i + 1, obs, exp[i]); end
            adv();
        end
        drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
        @(negedge clk); vecs++;
        if (obs !== 8'h04) begin errs++; $display("FAIL mul_in_exe: got %h want %h", obs, 8'h04); end
`else
        @(negedge clk); vecs++;
        if (obs !== 8'hC0) begin errs++; $display("FAIL mul_in_exe: got %h want %h", obs, 8'hC0); end
`endif
        adv();
        idle(4);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [4] = '{8'hC0, 8'hD0, 8'hD0, 8'h00};
        for (int m = 0; m < 2; m++) begin
            drive(1, 0, 0, 0, 0, 1, 0, 8 + m, 1, 0);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk); vecs++;
                if (obs !== exp[i]) begin errs++; $display("FAIL b2b_mul%0d_c%0d: got %h want %h", m, i + 1, obs, exp[i]); end
                adv();
            end
        end
        idle(3);
    endtask

    task automatic test_mul_reset();
        drive(1, 0, 0, 0, 0, 1, 0, 7, 1, 0);
        @(negedge clk); vecs++;
        if (obs !== 8'hC0) begin errs++; $display("FAIL mulrst_entry: got %h want %h", obs, 8'hC0); end
        adv();
        @(negedge clk); vecs++;
        if (obs !== 8'hD0) begin errs++; $display("FAIL mulrst_wait: got %h want %h", obs, 8'hD0); end
        clr = 1'b1;
        adv();
        clr = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); vecs++;
        if (obs !== 8'h00) begin errs++; $display("FAIL mulrst_after: got %h want %h", obs, 8'h00); end
        adv();
        @(negedge clk); vecs++;
        if (obs !== 8'h00) begin errs++; $display("FAIL mulrst_stays_run: got %h want %h", obs, 8'h00); end
        adv();
        idle(2);
    endtask

    task automatic test_branch();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk); vecs++;
        if (obs !== 8'h20) begin errs++; $display("FAIL branch_flush: got %h want %h", obs, 8'h20); end
        adv();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); vecs++;
        if (obs !== 8'h00) begin errs++; $display("FAIL branch_one_cycle: got %h want %h", obs, 8'h00); end
        adv();
        drive(1, 0, 0, 0, 0, 1, 1, 5, 0, 0);
        adv();
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk); vecs++;
        if (obs !== 8'hC0) begin errs++; $display("FAIL branch_in_stall: got %h want %h", obs, 8'hC0); end
        adv();
`ifdef HAZARD_FWD_EN
        @(negedge clk); vecs++;
        if (obs !== 8'h28) begin errs++; $display("FAIL branch_release: got %h want %h", obs, 8'h28); end
`else
        @(negedge clk); vecs++;
        if (obs !== 8'hC0) begin errs++; $display("FAIL branch_in_stall_mem: got %h want %h", obs, 8'hC0); end
        adv();
        @(negedge clk); vecs++;
        if (obs !== 8'h20) begin errs++; $display("FAIL branch_release: got %h want %h", obs, 8'h20); end
`endif
        adv();
        idle(3);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv();
        test_reset();
        test_fwd_chain();
        test_priority();
        test_load_use();
        test_mul();
        test_back_to_back();
        test_mul_reset();
        test_branch();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
